// File: rtl/fractal_sync_pkg.sv
// rtl/fractal_sync_pkg.sv - shared widths and types for the fractal sync barrier blocks
package fractal_sync_pkg;

    // Width of the back-routing source/destination mask carried by each barrier
    localparam int SD_WIDTH       = 2;
    // Width of the entry index carried on the completion channel
    localparam int DONE_IDX_WIDTH = 2;

    // One completion record: which entry finished and who to route the release to
    typedef struct packed {
        logic [DONE_IDX_WIDTH-1:0] idx;
        logic [SD_WIDTH-1:0]       sd;
    } done_t;

endpackage

// File: rtl/fractal_sync_mp_cnt_rf_if.sv
// rtl/fractal_sync_mp_cnt_rf_if.sv - completion channel of the multi-port barrier counter
interface fractal_sync_mp_cnt_rf_if #(
    parameter int IDX_WIDTH = 2,
    parameter int SD_WIDTH  = fractal_sync_pkg::SD_WIDTH
);
    logic                 done_valid_o;
    logic                 done_ready_i;
    logic [IDX_WIDTH-1:0] done_idx_o;
    logic [SD_WIDTH-1:0]  done_sd_o;

    modport master (output done_valid_o, output done_idx_o, output done_sd_o, input done_ready_i);
    modport slave  (input done_valid_o, input done_idx_o, input done_sd_o, output done_ready_i);
endinterface

// File: rtl/fractal_sync_cnt_entry.sv
// rtl/fractal_sync_cnt_entry.sv - state of one barrier entry (count, target, mask, busy/pending)
module fractal_sync_cnt_entry
    import fractal_sync_pkg::*;
#(
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [CNT_WIDTH:0]   inc_i,      // valid arrivals this cycle
    input  logic [CNT_WIDTH-1:0] tgt_i,      // target in force this cycle
    input  logic [SD_WIDTH-1:0]  sd_i,       // OR of the valid arrivals' masks
    input  logic                 clr_i,      // completion consumed
    output logic                 busy_o,
    output logic                 pending_o,
    output logic [CNT_WIDTH-1:0] target_o,
    output logic [SD_WIDTH-1:0]  sd_o,
    output logic                 over_o      // arrivals overshot the target
);
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [CNT_WIDTH-1:0] target_q, target_d;
    logic [SD_WIDTH-1:0]  sd_q, sd_d;
    logic                 busy_q, busy_d;
    logic                 pending_q, pending_d;
    logic [CNT_WIDTH:0]   sum;
    logic                 complete;

    // One bit wider than the counter so an overshoot never wraps back under the target
    assign sum      = {1'b0, count_q} + inc_i;
    assign complete = (inc_i != '0) && (sum >= {1'b0, tgt_i});
    assign over_o   = (inc_i != '0) && (sum >  {1'b0, tgt_i});

    // Next state; a consumed entry never sees arrivals, so clear and count are exclusive
    always_comb begin
        count_d   = count_q;
        target_d  = target_q;
        sd_d      = sd_q;
        busy_d    = busy_q;
        pending_d = pending_q;
        if (clr_i) begin
            pending_d = 1'b0;
            sd_d      = '0;
        end else if (inc_i != '0) begin
            sd_d     = sd_q | sd_i;
            target_d = tgt_i;
            if (complete) begin
                pending_d = 1'b1;
                busy_d    = 1'b0;
                count_d   = '0;
            end else begin
                busy_d  = 1'b1;
                count_d = sum[CNT_WIDTH-1:0];
            end
        end
    end

    // Entry state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q   <= '0;
            target_q  <= '0;
            sd_q      <= '0;
            busy_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            target_q  <= target_d;
            sd_q      <= sd_d;
            busy_q    <= busy_d;
            pending_q <= pending_d;
        end
    end

    assign busy_o    = busy_q;
    assign pending_o = pending_q;
    assign target_o  = target_q;
    assign sd_o      = sd_q;
endmodule

// File: rtl/fractal_sync_mp_cnt_rf.sv
// rtl/fractal_sync_mp_cnt_rf.sv - multi-port barrier counter register file with completion channel
module fractal_sync_mp_cnt_rf
    import fractal_sync_pkg::*;
#(
    parameter int N_REGS    = 4,
    parameter int IDX_WIDTH = 2,
    parameter int N_PORTS   = 2,
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 arrive_i [N_PORTS],
    input  logic [IDX_WIDTH-1:0] idx_i    [N_PORTS],
    input  logic [CNT_WIDTH-1:0] target_i [N_PORTS],
    input  logic [SD_WIDTH-1:0]  sd_i     [N_PORTS],
    output logic                 present_o[N_PORTS],
    output logic                 err_o    [N_PORTS],
    fractal_sync_mp_cnt_rf_if.master done_if
);
    localparam int SEL_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;

    if (2 ** IDX_WIDTH < N_REGS) begin : g_idx_check
        $fatal(1, "IDX_WIDTH cannot address N_REGS entries");
    end

    logic                 busy   [N_REGS];
    logic                 pend   [N_REGS];
    logic [CNT_WIDTH-1:0] tq     [N_REGS];
    logic [SD_WIDTH-1:0]  sdq    [N_REGS];
    logic                 over   [N_REGS];
    logic                 clr    [N_REGS];
    logic [CNT_WIDTH:0]   inc    [N_REGS];
    logic [CNT_WIDTH-1:0] tgt    [N_REGS];
    logic [SD_WIDTH-1:0]  sdor   [N_REGS];
    logic [N_PORTS-1:0]   hit    [N_REGS];
    logic [N_PORTS-1:0]   valid  [N_REGS];
    logic [N_PORTS-1:0]   err_q, err_d;
    logic                 lock_q, lock_d;
    logic [IDX_WIDTH-1:0] lock_idx_q, lock_idx_d;
    logic [IDX_WIDTH-1:0] first, sel;
    logic                 found;

    // Port decode: an idle entry adopts the lowest-index candidate's target, later ports must match it
    always_comb begin
        for (int e = 0; e < N_REGS; e++) begin
            tgt[e]   = busy[e] ? tq[e] : '0;
            inc[e]   = '0;
            sdor[e]  = '0;
            hit[e]   = '0;
            valid[e] = '0;
            for (int p = 0; p < N_PORTS; p++) begin
                hit[e][p] = arrive_i[p] && (idx_i[p][SEL_W-1:0] == SEL_W'(e));
                if (hit[e][p] && (target_i[p] != '0) && !pend[e]) begin
                    if (!busy[e] && (tgt[e] == '0)) tgt[e] = target_i[p];
                    if (target_i[p] == tgt[e]) begin
                        valid[e][p] = 1'b1;
                        inc[e]      = inc[e] + (CNT_WIDTH+1)'(1);
                        sdor[e]     = sdor[e] | sd_i[p];
                    end
                end
            end
        end
    end

    // Per-port error: any rejected arrival, plus every port that joined an overshooting entry
    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            err_d[p] = arrive_i[p];
            for (int e = 0; e < N_REGS; e++) begin
                if (valid[e][p]) err_d[p] = 1'b0;
            end
            for (int e = 0; e < N_REGS; e++) begin
                if (hit[e][p] && over[e]) err_d[p] = 1'b1;
            end
        end
    end

    // Occupancy of the entry each port addresses, regardless of whether it arrives
    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            present_o[p] = 1'b0;
            err_o[p]     = err_q[p];
            for (int e = 0; e < N_REGS; e++) begin
                if (idx_i[p][SEL_W-1:0] == SEL_W'(e)) present_o[p] = busy[e] | pend[e];
            end
        end
    end

    // Completion select: lowest pending entry, frozen while the consumer stalls
    always_comb begin
        found = 1'b0;
        first = '0;
        for (int e = 0; e < N_REGS; e++) begin
            if (pend[e] && !found) begin
                found = 1'b1;
                first = IDX_WIDTH'(e);
            end
        end
        sel                  = lock_q ? lock_idx_q : first;
        done_if.done_valid_o = found;
        done_if.done_idx_o   = found ? sel : '0;
        done_if.done_sd_o    = found ? sdq[sel] : '0;
        lock_d               = found && !done_if.done_ready_i;
        lock_idx_d           = sel;
        for (int e = 0; e < N_REGS; e++) begin
            clr[e] = found && done_if.done_ready_i && (sel == IDX_WIDTH'(e));
        end
    end

    // Error flags and completion lock
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            err_q      <= err_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    for (genvar e = 0; e < N_REGS; e++) begin : g_entry
        fractal_sync_cnt_entry #(.CNT_WIDTH(CNT_WIDTH)) u_entry (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .inc_i     (inc[e]),
            .tgt_i     (tgt[e]),
            .sd_i      (sdor[e]),
            .clr_i     (clr[e]),
            .busy_o    (busy[e]),
            .pending_o (pend[e]),
            .target_o  (tq[e]),
            .sd_o      (sdq[e]),
            .over_o    (over[e])
        );
    end
endmodule

// File: tb/tb_fractal_sync_mp_cnt_rf.sv
// tb/tb_fractal_sync_mp_cnt_rf.sv - self-checking bench for the multi-port barrier counter
module tb_fractal_sync_mp_cnt_rf;
    logic       clk = 1'b0;
    logic       rst_ni;
    logic       arrive [2];
    logic [1:0] idx    [2];
    logic [3:0] tgt    [2];
    logic [1:0] sd     [2];
    logic       present[2];
    logic       err    [2];
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    fractal_sync_mp_cnt_rf_if #(.IDX_WIDTH(2), .SD_WIDTH(2)) dif ();

    fractal_sync_mp_cnt_rf #(.N_REGS(4), .IDX_WIDTH(2), .N_PORTS(2), .CNT_WIDTH(4)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .arrive_i(arrive), .idx_i(idx), .target_i(tgt),
        .sd_i(sd), .present_o(present), .err_o(err), .done_if(dif)
    );

    typedef struct {
        logic [1:0] arr;
        logic [1:0] i0, i1;
        logic [3:0] t0, t1;
        logic [1:0] s0, s1;
        logic       rdy;
        logic       e_dv;
        logic [1:0] e_idx, e_sd, e_err;
    } vec_t;

    // Reference model: barrier state in plain arrays
    int m_cnt[4], m_tgt[4], m_sd[4];
    bit m_busy[4], m_pend[4];
    bit m_lock;
    int m_lock_idx;
    bit m_err[2];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] a, input int i0, t0, s0, i1, t1, s1,
                                input logic r, input logic dv, input int di, ds, input logic [1:0] e);
        vec_t v;
        v.arr = a; v.i0 = 2'(i0); v.t0 = 4'(t0); v.s0 = 2'(s0);
        v.i1 = 2'(i1); v.t1 = 4'(t1); v.s1 = 2'(s1); v.rdy = r;
        v.e_dv = dv; v.e_idx = 2'(di); v.e_sd = 2'(ds); v.e_err = e;
        return v;
    endfunction

    task automatic m_reset();
        for (int e = 0; e < 4; e++) begin
            m_cnt[e] = 0; m_tgt[e] = 0; m_sd[e] = 0; m_busy[e] = 0; m_pend[e] = 0;
        end
        m_lock = 0; m_lock_idx = 0; m_err[0] = 0; m_err[1] = 0;
    endtask

    function automatic void m_done(output bit dv, output int di, output int ds);
        dv = 0; di = 0; ds = 0;
        for (int e = 3; e >= 0; e--) if (m_pend[e]) begin dv = 1; di = e; end
        if (m_lock) di = m_lock_idx;
        if (dv) ds = m_sd[di];
    endfunction

    // Advance the model by one clock using the inputs currently applied
    task automatic m_step();
        bit dv; int di, ds; bit ok[2]; bit ovh[2];
        m_done(dv, di, ds);
        ok[0] = 0; ok[1] = 0; ovh[0] = 0; ovh[1] = 0;
        for (int e = 0; e < 4; e++) begin
            int eff, n, s;
            eff = m_busy[e] ? m_tgt[e] : 0; n = 0; s = 0;
            for (int p = 0; p < 2; p++) begin
                if (arrive[p] && idx[p] == e && tgt[p] != 0 && !m_pend[e]) begin
                    if (eff == 0) eff = tgt[p];
                    if (tgt[p] == eff) begin ok[p] = 1; n++; s |= sd[p]; end
                end
            end
            if (n > 0) begin
                m_sd[e] |= s; m_tgt[e] = eff;
                if (m_cnt[e] + n >= eff) begin
                    if (m_cnt[e] + n > eff)
                        for (int p = 0; p < 2; p++) if (arrive[p] && idx[p] == e) ovh[p] = 1;
                    m_pend[e] = 1; m_busy[e] = 0; m_cnt[e] = 0;
                end else begin
                    m_busy[e] = 1; m_cnt[e] += n;
                end
            end
        end
        if (dv && dif.done_ready_i) begin m_pend[di] = 0; m_sd[di] = 0; end
        for (int p = 0; p < 2; p++) m_err[p] = (arrive[p] && !ok[p]) || ovh[p];
        m_lock = dv && !dif.done_ready_i;
        m_lock_idx = di;
    endtask

    task automatic drive_vec(input vec_t v);
        arrive[0] = v.arr[0]; idx[0] = v.i0; tgt[0] = v.t0; sd[0] = v.s0;
        arrive[1] = v.arr[1]; idx[1] = v.i1; tgt[1] = v.t1; sd[1] = v.s1;
        dif.done_ready_i = v.rdy;
    endtask

    // Check outputs mid-cycle, then let the clock edge advance both DUT and model
    task automatic do_cycle(input bit tab_en, input vec_t v, input int row);
        bit dv; int di, ds;
        @(negedge clk);
        if (tab_en) begin
            chk($sformatf("tab%0d_valid", row), int'(dif.done_valid_o), int'(v.e_dv));
            chk($sformatf("tab%0d_idx", row), int'(dif.done_idx_o), int'(v.e_idx));
            chk($sformatf("tab%0d_sd", row), int'(dif.done_sd_o), int'(v.e_sd));
            chk($sformatf("tab%0d_err", row), int'({err[1], err[0]}), int'(v.e_err));
        end
        m_done(dv, di, ds);
        chk("mdl_valid", int'(dif.done_valid_o), int'(dv));
        chk("mdl_idx", int'(dif.done_idx_o), di);
        chk("mdl_sd", int'(dif.done_sd_o), ds);
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("mdl_err%0d", p), int'(err[p]), int'(m_err[p]));
            chk($sformatf("mdl_present%0d", p), int'(present[p]), int'(m_busy[idx[p]] | m_pend[idx[p]]));
        end
        @(posedge clk);
        m_step();
        #1;
    endtask

    vec_t tab[25];
    vec_t idle;

    initial begin
        idle = mk(2'b00, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0, 0, 0, 2'b00);
        rst_ni = 1'b0;
        drive_vec(idle);
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", int'(dif.done_valid_o), 0);
        chk("rst_idx", int'(dif.done_idx_o), 0);
        chk("rst_sd", int'(dif.done_sd_o), 0);
        chk("rst_err", int'({err[1], err[0]}), 0);
        chk("rst_present", int'({present[1], present[0]}), 0);
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        //             arr    i0 t0 s0 i1 t1 s1 rdy  dv  idx sd err{p1,p0}
        tab[0]  = mk(2'b01, 1, 2, 1, 0, 0, 0, 1'b1, 1'b0, 0, 0, 2'b00);
        tab[1]  = idle;
        tab[2]  = idle;
        tab[3]  = mk(2'b10, 0, 0, 0, 1, 2, 2, 1'b1, 1'b0, 0, 0, 2'b00);
        tab[4]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 1'b1, 1'b1, 1, 3, 2'b00);
        tab[5]  = idle;
        tab[6]  = mk(2'b11, 2, 2, 1, 2, 2, 2, 1'b1, 1'b0, 0, 0, 2'b00);
        tab[7]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 1'b1, 1'b1, 2, 3, 2'b00);
        tab[8]  = idle;
        tab[9]  = mk(2'b01, 3, 3, 1, 0, 0, 0, 1'b1, 1'b0, 0, 0, 2'b00);
        tab[10] = mk(2'b10, 0, 0, 0, 3, 2, 2, 1'b1, 1'b0, 0, 0, 2'b00);
        tab[11] = mk(2'b01, 3, 3, 0, 0, 0, 0, 1'b1, 1'b0, 0, 0, 2'b10);
        tab[12] = mk(2'b10, 0, 0, 0, 3, 3, 0, 1'b1, 1'b0, 0, 0, 2'b00);
        tab[13] = mk(2'b00, 0, 0, 0, 0, 0, 0, 1'b1, 1'b1, 3, 1, 2'b00);
        tab[14] = idle;
        tab[15] = mk(2'b11, 0, 1, 1, 3, 1, 2, 1'b0, 1'b0, 0, 0, 2'b00);
        tab[16] = mk(2'b00, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1, 0, 1, 2'b00);
        tab[17] = mk(2'b01, 0, 1, 2, 0, 0, 0, 1'b0, 1'b1, 0, 1, 2'b00);
        tab[18] = mk(2'b10, 0, 0, 0, 2, 0, 1, 1'b0, 1'b1, 0, 1, 2'b01);
        tab[19] = mk(2'b00, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1, 0, 1, 2'b10);
        tab[20] = mk(2'b00, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1, 0, 1, 2'b00);
        tab[21] = mk(2'b10, 0, 0, 0, 0, 1, 3, 1'b1, 1'b1, 0, 1, 2'b00);
        tab[22] = mk(2'b01, 0, 1, 2, 0, 0, 0, 1'b1, 1'b1, 3, 2, 2'b10);
        tab[23] = mk(2'b00, 0, 0, 0, 0, 0, 0, 1'b1, 1'b1, 0, 2, 2'b00);
        tab[24] = idle;
        for (int i = 0; i < 25; i++) begin
            drive_vec(tab[i]);
            do_cycle(1'b1, tab[i], i);
        end

        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < 2; p++) begin
                arrive[p] = 1'($urandom_range(0, 1));
                idx[p]    = 2'($urandom_range(0, 3));
                tgt[p]    = 4'($urandom_range(0, 3));
                sd[p]     = 2'($urandom_range(0, 3));
            end
            dif.done_ready_i = ($urandom_range(0, 3) != 0);
            do_cycle(1'b0, idle, n);
        end

        // Reset in the middle of a barrier discards it; a fresh target=1 completes next cycle
        rst_ni = 1'b0;
        #2;
        rst_ni = 1'b1;
        m_reset();
        drive_vec(mk(2'b01, 1, 2, 1, 0, 0, 0, 1'b1, 1'b0, 0, 0, 2'b00));
        do_cycle(1'b0, idle, 0);
        drive_vec(mk(2'b00, 1, 0, 0, 1, 0, 0, 1'b1, 1'b0, 0, 0, 2'b00));
        @(negedge clk);
        chk("midrst_busy_before", int'(present[0]), 1);
        rst_ni = 1'b0;
        m_reset();
        #1;
        chk("midrst_present", int'({present[1], present[0]}), 0);
        chk("midrst_valid", int'(dif.done_valid_o), 0);
        chk("midrst_err", int'({err[1], err[0]}), 0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        drive_vec(mk(2'b01, 1, 1, 2, 1, 0, 0, 1'b1, 1'b0, 0, 0, 2'b00));
        do_cycle(1'b0, idle, 0);
        drive_vec(idle);
        @(negedge clk);
        chk("post_rst_valid", int'(dif.done_valid_o), 1);
        chk("post_rst_idx", int'(dif.done_idx_o), 1);
        chk("post_rst_sd", int'(dif.done_sd_o), 2);
        chk("post_rst_err", int'(err[0]), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fractal_sync_mp_cnt_rf.md
FRACTAL_SYNC_MP_CNT_RF -- requirements
Module: fractal_sync_mp_cnt_rf

Interface
REQ-001 SHALL have parameter N_REGS, default 4: number of barrier entries.
REQ-002 SHALL have parameter IDX_WIDTH, default 2: idx_i width; 2**IDX_WIDTH >= N_REGS, checked by elaboration-time fatal assertion.
REQ-003 SHALL have parameter N_PORTS, default 2: arrival ports.
REQ-004 SHALL have parameter CNT_WIDTH, default 4: arrival counter and target width.
REQ-005 SHALL use localparam SD_WIDTH, taken from fractal_sync_pkg: back-routing source/destination mask width.
REQ-006 SHALL have clk_i, input, 1 bit: single clock; all state updates on its rising edge.
REQ-007 SHALL have rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have arrive_i[N_PORTS], input, 1 bit each: arrival request.
REQ-009 SHALL have idx_i[N_PORTS], input, IDX_WIDTH each: target entry; only the low $clog2(N_REGS) bits are used.
REQ-010 SHALL have target_i[N_PORTS], input, CNT_WIDTH each: arrivals required to complete.
REQ-011 SHALL have sd_i[N_PORTS], input, SD_WIDTH each: back-routing mask of the arrival.
REQ-012 SHALL have present_o[N_PORTS], output, 1 bit each: selected entry busy or pending (combinational from state).
REQ-013 SHALL have err_o[N_PORTS], output, 1 bit each: registered error flag for the previous cycle's arrival.
REQ-014 SHALL have done_valid_o, done_ready_i, done_idx_o (IDX_WIDTH), done_sd_o (SD_WIDTH): completion channel.

Function
REQ-015 SHALL keep per entry: count_q (CNT_WIDTH), target_q (CNT_WIDTH), sd_q (SD_WIDTH), busy_q, pending_q.
REQ-016 SHALL count an arrival as valid when arrive_i=1, target_i!=0, pending_q=0 for the entry, and either busy_q=0 or target_i==target_q.
REQ-017 SHALL set count_d = count_q + (number of valid arrivals to the entry this cycle), computed one bit wider than CNT_WIDTH.
REQ-018 SHALL, on an idle entry, latch target_q from the lowest-index valid port; other same-cycle ports with a different target are invalid.
REQ-019 SHALL set sd_d = sd_q OR the sd_i of every valid arrival to the entry (sticky).
REQ-020 SHALL, when count_d >= target, set pending_q, clear busy_q and count_q, and keep sd_d.
REQ-021 SHALL otherwise set busy_q=1 when any valid arrival hits the entry.
REQ-022 SHALL assert err_o[p] one cycle after an invalid arrival on port p.
REQ-023 SHALL also assert err_o one cycle later for every port hitting an entry whose count_d > target (overshoot); the entry still completes.
REQ-024 SHALL drive done_valid_o whenever any pending_q=1, with done_idx_o = lowest pending index and done_sd_o = that entry's sd_q; done_idx_o and done_sd_o are 0 when done_valid_o=0.
REQ-025 SHALL hold done_valid_o, done_idx_o and done_sd_o stable until done_valid_o and done_ready_i are both 1.
REQ-026 SHALL, on that handshake, clear the entry's pending_q and sd_q at the next edge.
REQ-027 SHALL make completion latency exactly 1 cycle: the completing arrival at edge t gives done_valid_o=1 after edge t, when no lower index is pending.
REQ-028 SHALL reject an arrival to an entry whose pending_q=1 in the same cycle as its handshake; the entry becomes idle next cycle.
REQ-029 SHALL accept target 1: a single arrival completes immediately.
REQ-030 SHALL make entries fully independent; simultaneous completions on several entries are each pending and drain lowest index first.

Reset
REQ-031 SHALL, on rst_ni=0 at any time, clear all count_q, target_q, sd_q, busy_q, pending_q and err_o asynchronously.
REQ-032 SHALL drive present_o=0, err_o=0, done_valid_o=0, done_idx_o=0 and done_sd_o=0 during reset; in-flight barriers are discarded.

Structure
REQ-033 SHALL take SD_WIDTH from fractal_sync_pkg and add a fractal_sync_pkg::done_t typedef there {idx, sd}, parametrised by localparam widths.
REQ-034 SHALL implement per-entry state in sub-module fractal_sync_cnt_entry, instantiated N_REGS times; the top holds port decode, popcount, priority select and err registers.

Verification
REQ-035 SHALL cover single arrival: N_PORTS=2, port0 idx=1, target=2, sd=01 at cycle 0 and port1 idx=1, target=2, sd=10 at cycle 3 -> done_valid_o at cycle 4 with idx=1, sd=11, err_o=0.
REQ-036 SHALL cover simultaneous arrival: both ports idx=2, target=2 in the same cycle -> done next cycle, idx=2.
REQ-037 SHALL cover mismatch: port0 target=3, then port1 same idx with target=2 -> err_o[1]=1 one cycle later, count stays 1.
REQ-038 SHALL cover backpressure: entries 0 and 3 complete together with done_ready_i=0 for 5 cycles -> idx=0 held stable; after ready, idx=0 then idx=3 on consecutive cycles.
REQ-039 SHALL cover pending reject: arrival to pending entry 0 -> err_o=1, sd unchanged; target=0 arrival -> err_o=1.
REQ-040 SHALL cover reset mid-barrier: count=1, rst_ni pulsed low -> all outputs 0; a fresh target=1 arrival completes in 1 cycle.
